// File: rtl/oka_103bit_seq_ctrl_pkg.sv
// Shared constants, state encoding and operand-split helpers for the
// sequential 103-bit overlap-free Karatsuba controller.
package oka_pkg;

    localparam int OKA_N = 103;          // operand width in coefficients
    localparam int OKA_H = 52;           // half width, (N+1)/2
    localparam int OKA_W = 2*OKA_N - 1;  // full product width
    localparam int OKA_P = 2*OKA_H - 1;  // half-product width

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        M1   = 3'd1,
        M2   = 3'd2,
        M3   = 3'd3,
        DONE = 3'd4
    } oka_seq_state_t;

    // Even-index coefficients: e[i] = v[2i].
    function automatic logic [OKA_H-1:0] even_half(input logic [OKA_N-1:0] v);
        logic [OKA_H-1:0] r;
        r = '0;
        for (int i = 0; i < OKA_H; i++) r[i] = v[2*i];
        return r;
    endfunction

    // Odd-index coefficients: o[i] = v[2i+1]; the top slot has no source bit.
    function automatic logic [OKA_H-1:0] odd_half(input logic [OKA_N-1:0] v);
        logic [OKA_H-1:0] r;
        r = '0;
        for (int i = 0; i < OKA_H-1; i++) r[i] = v[2*i+1];
        return r;
    endfunction

endpackage

// File: rtl/oka_103bit_seq_ctrl_if.sv
// Operand/result handshake bundle between the issue logic (master)
// and the sequential Karatsuba controller (slave).
interface oka_103bit_seq_ctrl_if;

    logic                       in_valid;
    logic                       in_ready;
    logic [oka_pkg::OKA_N-1:0]  in_a;
    logic [oka_pkg::OKA_N-1:0]  in_b;
    logic                       out_valid;
    logic                       out_ready;
    logic [oka_pkg::OKA_W-1:0]  out_y;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_y
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_y
    );

endinterface

// File: rtl/oka_103bit_seq_ctrl_recombine.sv
// Interleaves the three half products back into the 205-bit result:
//   even bit 2i   = P1[i] ^ P2[i-1]
//   odd  bit 2i+1 = P3[i] ^ P1[i] ^ P2[i]
module oka_103bit_recombine
    import oka_pkg::*;
(
    input  logic [OKA_P-1:0] p1_i,
    input  logic [OKA_P-1:0] p2_i,
    input  logic [OKA_P-1:0] p3_i,
    output logic [OKA_W-1:0] y_o
);

    // Top coefficients of P2 and P3 have no destination bit: P2 never
    // reaches degree 102 and P3[102] always equals P1[102].
    logic unused_top;
    assign unused_top = p2_i[OKA_P-1] ^ p3_i[OKA_P-1];

    // Combinational interleave of the even and odd result coefficients.
    always_comb begin
        // NOTE: default every output bit first so no path leaves y_o unassigned (no latch).
        y_o    = '0;
        y_o[0] = p1_i[0];
        for (int i = 1; i < OKA_N; i++) begin
            y_o[2*i] = p1_i[i] ^ p2_i[i-1];
        end
        for (int i = 0; i < OKA_N-1; i++) begin
            y_o[2*i+1] = p3_i[i] ^ p1_i[i] ^ p2_i[i];
        end
    end

endmodule

// File: rtl/oka_103bit_seq_ctrl.sv
// Sequential 103-bit GF(2) multiplier controller: drives one shared 52-bit
// multiplier with the even, odd and even^odd halves over three cycles and
// recombines the partial products into a 205-bit result.
module oka_103bit_seq_ctrl
    import oka_pkg::*;
#(
    parameter int N = OKA_N,
    parameter int H = OKA_H
)
(
    input  logic                  clk,
    input  logic                  rst_n,
    oka_103bit_seq_ctrl_if.slave  bus,
    output logic [H-1:0]          mul_a,
    output logic [H-1:0]          mul_b,
    input  logic [2*H-2:0]        mul_y,
    output logic                  busy
);

    localparam logic [2:0] S_IDLE = IDLE;
    localparam logic [2:0] S_M1   = M1;
    localparam logic [2:0] S_M2   = M2;
    localparam logic [2:0] S_M3   = M3;
    localparam logic [2:0] S_DONE = DONE;

    logic [2:0]       state_q, state_d;
    logic [N-1:0]     a_q, b_q;
    logic [2*H-2:0]   p1_q, p2_q;
    logic [2*N-2:0]   y_q;
    logic [2*N-2:0]   recomb_y;
    logic [H-1:0]     ae, ao, be, bo;

    assign ae = even_half(a_q);
    assign ao = odd_half(a_q);
    assign be = even_half(b_q);
    assign bo = odd_half(b_q);

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.out_y     = y_q;
    assign busy          = (state_q != S_IDLE);

    oka_103bit_recombine u_recombine (
        .p1_i (p1_q),
        .p2_i (p2_q),
        .p3_i (mul_y),
        .y_o  (recomb_y)
    );

    // Next-state logic: fixed M1-M2-M3 walk, handshakes gate IDLE and DONE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.in_valid)  state_d = S_M1;
            S_M1:    state_d = S_M2;
            S_M2:    state_d = S_M3;
            S_M3:    state_d = S_DONE;
            S_DONE:  if (bus.out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Multiplier operands decoded from the state; zero outside M1-M3.
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (state_q)
            S_M1: begin mul_a = ae;      mul_b = be;      end
            S_M2: begin mul_a = ao;      mul_b = bo;      end
            S_M3: begin mul_a = ae ^ ao; mul_b = be ^ bo; end
            default: ;
        endcase
    end

    // State, operand capture, partial-product capture and result load.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: datapath registers are cleared too, so no stale operand or result survives a reset.
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            p1_q    <= '0;
            p2_q    <= '0;
            y_q     <= '0;
        end else begin
            // NOTE: non-blocking updates so every register samples pre-edge values.
            state_q <= state_d;
            if (state_q == S_IDLE && bus.in_valid) begin
                a_q <= bus.in_a;
                b_q <= bus.in_b;
            end
            if (state_q == S_M1) p1_q <= mul_y;
            if (state_q == S_M2) p2_q <= mul_y;
            if (state_q == S_M3) y_q  <= recomb_y;
        end
    end

endmodule

// File: tb/tb_oka_103bit_seq_ctrl.sv
// Directed and random self-checking bench for oka_103bit_seq_ctrl; supplies
// a behavioural carry-less 52-bit multiplier on the mul_* ports.
module tb_oka_103bit_seq_ctrl;

    localparam int N = 103;
    localparam int H = 52;
    localparam int W = 2*N - 1;

    logic           clk;
    logic           rst_n;
    logic [H-1:0]   mul_a, mul_b;
    logic [2*H-2:0] mul_y;
    logic           busy;

    int checks = 0;
    int errors = 0;

    oka_103bit_seq_ctrl_if bus();

    oka_103bit_seq_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .mul_a (mul_a),
        .mul_b (mul_b),
        .mul_y (mul_y),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Schoolbook carry-less products (reference, independent of Karatsuba).
    function automatic logic [W-1:0] clmul(input logic [N-1:0] a, input logic [N-1:0] b);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) if (b[i]) r = r ^ (W'(a) << i);
        return r;
    endfunction

    function automatic logic [2*H-2:0] clmul52(input logic [H-1:0] a, input logic [H-1:0] b);
        logic [2*H-2:0] r;
        r = '0;
        for (int i = 0; i < H; i++) if (b[i]) r = r ^ ((2*H-1)'(a) << i);
        return r;
    endfunction

    function automatic logic [H-1:0] evens(input logic [N-1:0] v);
        logic [H-1:0] r;
        r = '0;
        for (int i = 0; i < H; i++) if (2*i < N) r[i] = v[2*i];
        return r;
    endfunction

    function automatic logic [H-1:0] odds(input logic [N-1:0] v);
        logic [H-1:0] r;
        r = '0;
        for (int i = 0; i < H; i++) if (2*i+1 < N) r[i] = v[2*i+1];
        return r;
    endfunction

    // External shared multiplier model.
    always_comb mul_y = clmul52(mul_a, mul_b);

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full operation from IDLE; hold > 0 keeps out_ready low that many extra DONE cycles.
    task automatic run_op(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic [W-1:0] exp_y, input bit check_mul, input int hold);
        int budget;
        budget = 0;
        while (bus.in_ready !== 1'b1 && budget < 20) begin
            step();
            budget++;
        end
        check({tag, " ready_at_start"}, bus.in_ready, 1'b1);
        bus.in_valid  = 1'b1;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.out_ready = (hold == 0);
        step();  // M1
        bus.in_valid = 1'b0;
        check({tag, " in_ready_m1"}, bus.in_ready, 1'b0);
        if (check_mul) begin
            check({tag, " mul_a_m1"}, mul_a, evens(a));
            check({tag, " mul_b_m1"}, mul_b, evens(b));
        end
        step();  // M2
        if (check_mul) begin
            check({tag, " mul_a_m2"}, mul_a, odds(a));
            check({tag, " mul_b_m2"}, mul_b, odds(b));
        end
        step();  // M3
        check({tag, " out_valid_m3"}, bus.out_valid, 1'b0);
        if (check_mul) begin
            check({tag, " mul_a_m3"}, mul_a, evens(a) ^ odds(a));
            check({tag, " mul_b_m3"}, mul_b, evens(b) ^ odds(b));
        end
        step();  // DONE, cycle 4 after acceptance
        check({tag, " out_valid_done"}, bus.out_valid, 1'b1);
        check({tag, " out_y"}, bus.out_y, exp_y);
        check({tag, " mul_a_done"}, mul_a, '0);
        if (hold > 0) begin
            bus.in_valid = 1'b1;
            bus.in_a     = ~a;
            bus.in_b     = ~b;
            for (int h = 0; h < hold; h++) begin
                step();
                check({tag, " hold_out_valid"}, bus.out_valid, 1'b1);
                check({tag, " hold_out_y"}, bus.out_y, exp_y);
                check({tag, " hold_in_ready"}, bus.in_ready, 1'b0);
            end
            bus.in_valid  = 1'b0;
            bus.out_ready = 1'b1;
        end
        step();  // back to IDLE
        check({tag, " in_ready_after"}, bus.in_ready, 1'b1);
        check({tag, " busy_after"}, busy, 1'b0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] a, b;
        logic [W-1:0] e;
        int           ready_cycles;

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b0;
        step();
        step();
        check("rst in_ready", bus.in_ready, 1'b1);
        check("rst out_valid", bus.out_valid, 1'b0);
        check("rst busy", busy, 1'b0);
        check("rst out_y", bus.out_y, '0);
        check("rst mul_a", mul_a, '0);
        check("rst mul_b", mul_b, '0);
        rst_n = 1'b1;
        step();

        // 1 * 1 = 1; mul_a walks 1, 0, 1.
        run_op("one", N'(1), N'(1), W'(1), 1'b1, 0);
        // (1+x)^2 = 1+x^2: odd term cancels.
        run_op("three", N'(3), N'(3), W'(5), 1'b1, 0);
        // Top coefficients.
        a = {1'b1, 102'b0};
        e = {1'b1, 204'b0};
        run_op("top102", a, a, e, 1'b1, 0);
        a = {2'b01, 101'b0};
        e = {3'b001, 202'b0};
        run_op("top101", a, a, e, 1'b1, 0);

        // 200 back-to-back random pairs with out_ready held high.
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        ready_cycles  = 0;
        for (int k = 0; k < 200; k++) begin
            a = N'({$urandom, $urandom, $urandom, $urandom});
            b = N'({$urandom, $urandom, $urandom, $urandom});
            bus.in_a = a;
            bus.in_b = b;
            for (int c = 0; c < 5; c++) begin
                if (bus.in_ready === 1'b1) ready_cycles++;
                if (c == 4) check($sformatf("rand%0d out_y", k), bus.out_y, clmul(a, b));
                step();
            end
        end
        bus.in_valid = 1'b0;
        check("rand ready_cycles", W'(ready_cycles), W'(200));

        // Output stall: 10 extra DONE cycles with a competing in_valid.
        run_op("stall", N'(6), N'(3), W'(10), 1'b0, 10);

        // Reset during M2 abandons the operation.
        bus.in_valid = 1'b1;
        bus.in_a     = N'(7);
        bus.in_b     = N'(7);
        step();  // M1
        bus.in_valid = 1'b0;
        step();  // M2
        check("pre_rst busy", busy, 1'b1);
        rst_n = 1'b0;
        step();
        check("midrst in_ready", bus.in_ready, 1'b1);
        check("midrst out_valid", bus.out_valid, 1'b0);
        check("midrst busy", busy, 1'b0);
        check("midrst mul_a", mul_a, '0);
        check("midrst out_y", bus.out_y, '0);
        rst_n = 1'b1;
        // (1+x^2)(1+x+x^2) = 1+x+x^3+x^4.
        run_op("post_rst", N'(5), N'(7), W'(27), 1'b1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
